// File: rtl/isa_brc_gen.sv
// Conditional branch executor for the ISA execute stage.
// Compares two registers, then loads the IP and optionally writes a link register.
module isa_brc_gen #(
  parameter int WIDTH     = 64,
  parameter int REG_IDX_W = 4,
  parameter int INSN_LEN  = 8,
  parameter int LINK_EN   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enabled,
  input  logic [2:0]           cond,
  input  logic                 rel,
  input  logic                 link,
  input  logic [REG_IDX_W-1:0] r0,
  input  logic [REG_IDX_W-1:0] r1,
  input  logic [REG_IDX_W-1:0] r2,
  input  logic [REG_IDX_W-1:0] rl,
  input  logic [WIDTH-1:0]     ip_cur,
  input  logic [WIDTH-1:0]     reg_out,
  output logic [REG_IDX_W-1:0] reg_id,
  output logic                 reg_re,
  output logic                 reg_we,
  output logic [WIDTH-1:0]     reg_in,
  output logic                 ip_set,
  output logic [WIDTH-1:0]     ip_val,
  output logic                 taken,
  output logic                 finished
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ_A, S_READ_B, S_EVAL,
    S_READ_T, S_LINK, S_SET, S_DONE
  } state_t;

  state_t               state_q;
  logic [2:0]           cond_q;
  logic                 rel_q;
  logic                 link_q;
  logic [REG_IDX_W-1:0] r1_q;
  logic [REG_IDX_W-1:0] r2_q;
  logic [REG_IDX_W-1:0] rl_q;
  logic [WIDTH-1:0]     ip_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [REG_IDX_W-1:0] reg_id_q;
  logic                 reg_re_q;
  logic                 reg_we_q;
  logic [WIDTH-1:0]     reg_in_q;
  logic                 ip_set_q;
  logic [WIDTH-1:0]     ip_val_q;
  logic                 taken_q;
  logic                 fin_q;

  logic                 hit_d;
  logic [WIDTH-1:0]     tgt_d;
  logic [WIDTH-1:0]     lnk_d;

  assign reg_id   = reg_id_q;
  assign reg_re   = reg_re_q;
  assign reg_we   = reg_we_q;
  assign reg_in   = reg_in_q;
  assign ip_set   = ip_set_q;
  assign ip_val   = ip_val_q;
  assign taken    = taken_q;
  assign finished = fin_q;

  // Branch condition on the latched operands
  always_comb begin
    hit_d = 1'b0;
    unique case (cond_q)
      3'd0: hit_d = (a_q == b_q);
      3'd1: hit_d = (a_q != b_q);
      3'd2: hit_d = ($signed(a_q) <  $signed(b_q));
      3'd3: hit_d = ($signed(a_q) >= $signed(b_q));
      3'd4: hit_d = (a_q <  b_q);
      3'd5: hit_d = (a_q >= b_q);
      3'd6: hit_d = 1'b1;
      3'd7: hit_d = 1'b0;
    endcase
  end

  // Target and return address, both wrapping silently
  always_comb begin
    tgt_d = rel_q ? (ip_q + reg_out) : reg_out;
    lnk_d = ip_q + WIDTH'(INSN_LEN);
  end

  // Sequencer with registered outputs; enabled low aborts to idle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cond_q   <= '0;
      rel_q    <= 1'b0;
      link_q   <= 1'b0;
      r1_q     <= '0;
      r2_q     <= '0;
      rl_q     <= '0;
      ip_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      reg_id_q <= '0;
      reg_re_q <= 1'b0;
      reg_we_q <= 1'b0;
      reg_in_q <= '0;
      ip_set_q <= 1'b0;
      ip_val_q <= '0;
      taken_q  <= 1'b0;
      fin_q    <= 1'b0;
    end else if (!enabled) begin
      state_q  <= S_IDLE;
      reg_re_q <= 1'b0;
      reg_we_q <= 1'b0;
      ip_set_q <= 1'b0;
      taken_q  <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cond_q   <= cond;
          rel_q    <= rel;
          link_q   <= (LINK_EN != 0) && link;
          r1_q     <= r1;
          r2_q     <= r2;
          rl_q     <= rl;
          ip_q     <= ip_cur;
          reg_id_q <= r0;
          reg_re_q <= 1'b1;
          state_q  <= S_READ_A;
        end
        S_READ_A: begin
          a_q      <= reg_out;
          reg_id_q <= r1_q;
          state_q  <= S_READ_B;
        end
        S_READ_B: begin
          b_q      <= reg_out;
          reg_re_q <= 1'b0;
          state_q  <= S_EVAL;
        end
        S_EVAL: begin
          taken_q <= hit_d;
          if (hit_d) begin
            reg_id_q <= r2_q;
            reg_re_q <= 1'b1;
            state_q  <= S_READ_T;
          end else begin
            fin_q   <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_READ_T: begin
          reg_re_q <= 1'b0;
          ip_val_q <= tgt_d;
          if (link_q) begin
            reg_id_q <= rl_q;
            reg_in_q <= lnk_d;
            reg_we_q <= 1'b1;
            state_q  <= S_LINK;
          end else begin
            ip_set_q <= 1'b1;
            state_q  <= S_SET;
          end
        end
        S_LINK: begin
          reg_we_q <= 1'b0;
          ip_set_q <= 1'b1;
          state_q  <= S_SET;
        end
        S_SET: begin
          ip_set_q <= 1'b0;
          fin_q    <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/isa_brc_gen.md
Name: isa_brc_gen

Overview:
- Parametrised conditional-branch executor for the ISA execution stage; successor to the fixed-condition branch unit.
- Reads two operand registers and compares them internally using a runtime-selected condition.
- On a taken branch: reads the target register, optionally forms a PC-relative target, optionally writes a link (return address) register, then pulses the IP update.
- Shares the register-file read/write port and the `enabled`/`finished` handshake used by all ISA units.

Parameters:
- WIDTH, 64: data, register and IP width in bits.
- REG_IDX_W, 4: register index width.
- INSN_LEN, 8: byte length of the branch instruction; the link value is ip_cur + INSN_LEN.
- LINK_EN, 1: 1 = link write supported; 0 = `link` input ignored and LINK state never entered.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- enabled  in  1  level; high = execute this instruction, low = abort/return to IDLE.
- cond  in  3  condition code: 0 EQ, 1 NE, 2 LT signed, 3 GE signed, 4 LTU, 5 GEU, 6 ALWAYS, 7 NEVER.
- rel  in  1  1 = target is ip_cur + reg[r2]; 0 = target is reg[r2].
- link  in  1  1 = write ip_cur + INSN_LEN to reg[rl] before the IP update.
- r0, r1, r2, rl  in  REG_IDX_W each  operand A, operand B, target and link register indices.
- ip_cur  in  WIDTH  IP of this instruction.
- reg_out  in  WIDTH  register-file read data; valid the cycle after reg_re/reg_id are presented.
- reg_id  out  REG_IDX_W  register index for read or write.
- reg_re  out  1  register read enable.
- reg_we  out  1  register write enable (one-cycle pulse).
- reg_in  out  WIDTH  register write data.
- ip_set  out  1  one-cycle IP load strobe.
- ip_val  out  WIDTH  new IP; valid while ip_set is high and held afterwards.
- taken  out  1  branch outcome; valid from EVAL exit until IDLE.
- finished  out  1  instruction complete; held high until enabled falls.

Behaviour:
- Reset (rst=1 at a rising edge): state IDLE; reg_id, reg_re, reg_we, reg_in, ip_set, ip_val, taken, finished all 0. rst has priority over everything.
- enabled=0 at a rising edge, rst=0: state IDLE; reg_re, reg_we, ip_set, finished, taken cleared. ip_val and reg_in keep their values. This is a legal abort from any state.
- IDLE, enabled=1:
  - Latch cond, rel, link (forced 0 if LINK_EN=0), r1, r2, rl and ip_cur.
  - reg_id<=r0, reg_re<=1; go to READ_A.
  - Input changes after this latch are ignored until the next IDLE.
- READ_A: A<=reg_out; reg_id<=r1; go to READ_B.
- READ_B: B<=reg_out; reg_re<=0; go to EVAL.
- EVAL: evaluate the latched condition on A, B.
  - EQ: A==B. NE: A!=B.
  - LT/GE: two's-complement signed compare. LTU/GEU: unsigned compare.
  - ALWAYS: 1. NEVER: 0.
  - taken<=result.
  - Taken: reg_id<=r2, reg_re<=1; go to READ_T.
  - Not taken: finished<=1; go to DONE.
- READ_T:
  - reg_re<=0.
  - ip_val<= rel ? (ip_cur + reg_out) mod 2^WIDTH : reg_out. Wrap-around is silent.
  - If link: reg_id<=rl, reg_in<=(ip_cur+INSN_LEN) mod 2^WIDTH, reg_we<=1; go to LINK.
  - Else: ip_set<=1; go to SET.
- LINK: reg_we<=0; ip_set<=1; go to SET.
- SET: ip_set<=0; finished<=1; go to DONE.
- DONE: hold all outputs. finished stays 1 while enabled=1. No re-execution until enabled has been low for at least one rising edge.
- Latency, counted in rising edges with enabled=1, starting at the IDLE edge:
  - Not taken: finished high after edge 4.
  - Taken: ip_set high after edge 5; finished high after edge 6.
  - Taken with link: reg_we high after edge 5, ip_set high after edge 6, finished high after edge 7.
- Invariants:
  - reg_re and reg_we are never high together.
  - ip_set and reg_we are never high together.
  - ip_set is exactly one cycle wide per taken branch; zero pulses if not taken or aborted before SET.
- rl == r2 or rl == r0: the link write happens after all reads; no hazard.
- Abort between LINK and SET: the link register is already written and the IP is not updated. The controller must not abort once ip_set is pending.

Test Plan:
- Stimulus: cond=EQ, reg[r0]=5, reg[r1]=5, rel=0, reg[r2]=0x100, link=0. Response: ip_set pulses once after edge 5 with ip_val=0x100; finished after edge 6; taken=1.
- Stimulus: cond=LT, A=0xFFFF_FFFF_FFFF_FFFF, B=1. Response: taken=1 (signed -1<1). Same operands with cond=LTU: taken=0, finished after edge 4, no ip_set.
- Stimulus: rel=1, ip_cur=0xFFFF_FFFF_FFFF_FFF8, reg[r2]=0x10, cond=ALWAYS. Response: ip_val=0x8 (wrap).
- Stimulus: link=1, LINK_EN=1, ip_cur=0x40, rl=3, cond=ALWAYS. Response: reg_we pulse with reg_id=3 and reg_in=0x48 after edge 5; ip_set after edge 6; finished after edge 7. With LINK_EN=0: no reg_we, finished after edge 6.
- Stimulus: enabled dropped while in READ_B, then raised again with new r0/r1. Response: IDLE next edge, all strobes 0; fresh execution uses the new operands. Separately, rst asserted in DONE: every output 0 on the next edge.
- Stimulus: cond=NEVER, enabled held 10 cycles. Response: finished high from edge 4 onward, taken=0, ip_set never asserted, reg_re low from edge 3.
